timebase_ctrl: RTL and testbench
================================

// Module: timebase_ctrl
// PURPOSE
//  Run-time controller for the system timebase. Sequences a programmable divide counter.
//  Emits a one-cycle Tick enable and a 50%-duty square wave Sq_out.
//  Supports start/stop and periodic or one-shot operation.
//  Sits between the top-level control FSM and every block that needs a slow tick
//  (display refresh, debounce, ALU step): they consume Tick as an enable, not as a clock.
//  Divisor and mode load through a valid/ready config port, accepted only while idle.
// PARAMETERS
//  CNT_W        25       width of divisor and counter
//  DEFAULT_DIV  249_999  divisor after reset; 50 MHz Clk -> Tick every 250_000 cycles
// PORTS
//  Clk        in   1      system clock, rising edge
//  Reset_n    in   1      asynchronous, active-low reset
//  Cfg_valid  in   1      config word offered
//  Cfg_ready  out  1      config accepted this cycle (high only in IDLE)
//  Cfg_div    in   CNT_W  divisor; period = Cfg_div+1 cycles
//  Cfg_oneshot in  1      1 = single Tick then stop; 0 = periodic
//  Start      in   1      begin counting (level, sampled in IDLE only)
//  Stop       in   1      abort counting (level)
//  Tick       out  1      one-cycle pulse at each terminal count
//  Sq_out     out  1      toggles on every Tick
//  Busy       out  1      high while in RUN
//  Done       out  1      one-cycle pulse with the final Tick of a one-shot
// BEHAVIOUR
//  Reset (async, Reset_n=0)
//   - state=IDLE, count=0, div=DEFAULT_DIV, oneshot=0.
//   - Tick, Sq_out, Busy and Done are all 0.
//   - Asserting reset mid-run aborts immediately with no Done.
//  All outputs are registered except Cfg_ready, which equals (state==IDLE).
//  States
//   - IDLE: Cfg_ready=1. Cfg_valid at an edge loads div and oneshot.
//   - IDLE -> RUN: Start=1 and Stop=0. Count is cleared to 0.
//     If config and Start arrive at the same edge, the new div/oneshot apply to this run.
//   - RUN: each edge, count==div ? (count<=0, Tick<=1, Sq_out<=~Sq_out) : (count<=count+1, Tick<=0).
//   - RUN -> IDLE on terminal count when oneshot=1. Done<=1 on the same edge as Tick<=1.
//   - RUN -> IDLE on Stop=1. Count is cleared; Tick and Done are forced to 0; Sq_out is cleared to 0.
//     Stop wins over a coincident terminal count: no Tick and no Done.
//  Latency
//   - Start sampled at edge E0. First Tick is high after edge E0+div+1.
//   - After that, Tick repeats every div+1 cycles.
//  Boundaries
//   - div=0: Tick is high every cycle in RUN; Sq_out toggles every cycle.
//   - div=2^CNT_W-1: count reaches all-ones and then wraps to 0 with a Tick; there is no overflow state.
//   - Start while RUN is ignored; there is no phase restart.
//   - Cfg_valid while RUN is not accepted (Cfg_ready=0); the initiator must hold it until IDLE.
//   - Start and Stop together in IDLE: remain in IDLE.
//   - Busy = (state==RUN), registered with the state.
// STRUCTURE
//  - Shared include timebase_defs.vh holds:
//     state encodings IDLE=1'b0, RUN=1'b1;
//     DEFAULT_DIV_100HZ=249_999;
//     CNT_W=25.
//  - One sub-module, tick_counter (CNT_W): inputs clr, en, div; outputs count and tc.
//    tc = en && count==div. The counter wraps to 0 on tc.
//  - This top holds the FSM, the config registers, and the Sq_out/Done/Tick registers.
// TESTING
//  1. Reset, no config, Start=1 for 1 cycle -> first Tick 250_000 cycles later, period 250_000;
//     Sq_out toggles on each Tick.
//  2. Cfg_div=3, Cfg_oneshot=0, then Start -> Tick on cycles 4, 8, 12 after Start;
//     Sq_out toggles 0->1->0->1; Busy=1 throughout.
//  3. Cfg_div=5, Cfg_oneshot=1, Start -> a single Tick and Done together 6 cycles after Start;
//     Busy drops the following cycle; no further Ticks.
//  4. Cfg_div=0, periodic -> Tick is high every cycle.
//     Stop asserted on the same edge as a terminal count -> no Tick, no Done, Sq_out=0, IDLE.
//  5. Cfg_valid pulsed with Cfg_div=7 during RUN -> Cfg_ready=0 and the old period is kept.
//     After Stop, the held Cfg_valid loads div=7 and the next run has period 8.
//  6. Reset_n pulled low mid-count with div=9, count=4 -> all outputs are 0 at once.
//     div returns to 249_999; a Start after release gives a 250_000-cycle period.

Source files
------------

// File: rtl/timebase_ctrl_pkg.sv
// rtl/timebase_ctrl_pkg.sv - shared state encodings and defaults for the timebase controller
package timebase_ctrl_pkg;

    localparam int DEF_CNT_W         = 25;
    localparam int DEFAULT_DIV_100HZ = 249_999;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tb_state_t;

endpackage

// File: rtl/timebase_ctrl_tick_counter.sv
// rtl/timebase_ctrl_tick_counter.sv - divide counter with terminal-count flag
module tick_counter #(
    parameter int CNT_W = 25
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_div,
    output logic [CNT_W-1:0] o_count,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;
    logic             w_tc;

    assign w_tc    = i_en && (r_count == i_div);
    assign o_tc    = w_tc;
    assign o_count = r_count;

    // Wrap on tc also covers div = all-ones: no overflow state exists.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            if (w_tc) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + ONE;
            end
        end
    end

endmodule

// File: rtl/timebase_ctrl.sv
// rtl/timebase_ctrl.sv - run-time timebase: programmable tick, square wave, one-shot/periodic
module timebase_ctrl
    import timebase_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEFAULT_DIV = DEFAULT_DIV_100HZ
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Cfg_valid,
    output logic             Cfg_ready,
    input  logic [CNT_W-1:0] Cfg_div,
    input  logic             Cfg_oneshot,
    input  logic             Start,
    input  logic             Stop,
    output logic             Tick,
    output logic             Sq_out,
    output logic             Busy,
    output logic             Done
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    tb_state_t        r_state;
    tb_state_t        w_next_state;
    logic [CNT_W-1:0] r_div;
    logic             r_oneshot;
    logic             r_tick;
    logic             r_sq;
    logic             r_busy;
    logic             r_done;

    logic             w_idle;
    logic             w_run;
    logic             w_clr;
    logic             w_en;
    logic             w_tc;
    logic [CNT_W-1:0] w_count;
    logic             w_unused;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_run    = (r_state == ST_RUN);
    // Stop suppresses the terminal count so it wins over a coincident Tick/Done.
    assign w_clr    = w_idle || Stop;
    assign w_en     = w_run && !Stop;
    assign w_unused = ^w_count;

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_div   (r_div),
        .o_count (w_count),
        .o_tc    (w_tc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (Start && !Stop) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    w_next_state = ST_IDLE;
                end else if (w_tc && r_oneshot) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Config loads in IDLE even on the Start edge, so it governs the run it starts.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div     <= RST_DIV;
            r_oneshot <= 1'b0;
        end else if (w_idle && Cfg_valid) begin
            r_div     <= Cfg_div;
            r_oneshot <= Cfg_oneshot;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tick <= 1'b0;
            r_sq   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_tick <= w_tc;
            r_done <= w_tc && r_oneshot;
            r_busy <= (w_next_state == ST_RUN);
            if (w_run && Stop) begin
                r_sq <= 1'b0;
            end else if (w_tc) begin
                r_sq <= ~r_sq;
            end
        end
    end

    assign Cfg_ready = w_idle;
    assign Tick      = r_tick;
    assign Sq_out    = r_sq;
    assign Busy      = r_busy;
    assign Done      = r_done;

endmodule

// File: tb/tb_timebase_ctrl.sv
// tb/tb_timebase_ctrl.sv - scoreboard bench for timebase_ctrl
module tb_timebase_ctrl;

    localparam int CW     = 25;
    localparam int TB_DEF = 99;

    logic          Clk         = 1'b0;
    logic          Reset_n     = 1'b0;
    logic          Cfg_valid   = 1'b0;
    logic [CW-1:0] Cfg_div     = '0;
    logic          Cfg_oneshot = 1'b0;
    logic          Start       = 1'b0;
    logic          Stop        = 1'b0;
    logic          Cfg_ready;
    logic          Tick;
    logic          Sq_out;
    logic          Busy;
    logic          Done;

    timebase_ctrl #(
        .CNT_W       (CW),
        .DEFAULT_DIV (TB_DEF)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Cfg_valid   (Cfg_valid),
        .Cfg_ready   (Cfg_ready),
        .Cfg_div     (Cfg_div),
        .Cfg_oneshot (Cfg_oneshot),
        .Start       (Start),
        .Stop        (Stop),
        .Tick        (Tick),
        .Sq_out      (Sq_out),
        .Busy        (Busy),
        .Done        (Done)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int   at;
        logic sq;
        logic done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_sq   = 1'b0;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Monitor: every Tick must match the head of the scoreboard in cycle, Sq_out and Done.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (sb.size() > 0 && cyc > sb[0].at) begin
                check("tick_missing", cyc, sb[0].at);
                void'(sb.pop_front());
            end
            if (Tick) begin
                if (sb.size() == 0) begin
                    check("unexpected_tick", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("tick_cycle", cyc, mon_e.at);
                    check("tick_sq", Sq_out, mon_e.sq);
                    check("tick_done", Done, mon_e.done);
                end
            end else if (Done) begin
                check("done_without_tick", 1, 0);
            end
        end
    end

    task automatic nxt();
        @(negedge Clk);
        #1;
    endtask

    task automatic push_ticks(input int e0, input int per, input int n, input logic done_last);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            exp_sq = ~exp_sq;
            e.at   = e0 + k * per;
            e.sq   = exp_sq;
            e.done = done_last && (k == n);
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            nxt();
            n++;
        end
        if (sb.size() > 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic cfg(input int div, input logic os);
        Cfg_valid   = 1'b1;
        Cfg_div     = CW'(div);
        Cfg_oneshot = os;
        check("cfg_ready_idle", Cfg_ready, 1);
        nxt();
        Cfg_valid = 1'b0;
    endtask

    task automatic stop_run(input string tag);
        Stop = 1'b1;
        nxt();
        Stop = 1'b0;
        check({tag, "_busy"}, Busy, 0);
        check({tag, "_sq"}, Sq_out, 0);
        check({tag, "_ready"}, Cfg_ready, 1);
        exp_sq = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;

        repeat (3) nxt();
        check("rst_tick", Tick, 0);
        check("rst_sq", Sq_out, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_ready", Cfg_ready, 1);
        Reset_n = 1'b1;
        nxt();

        // Default divisor after reset, periodic.
        Start = 1'b1;
        e0    = cyc + 1;
        push_ticks(e0, TB_DEF + 1, 3, 1'b0);
        nxt();
        Start = 1'b0;
        check("t1_busy", Busy, 1);
        check("t1_ready", Cfg_ready, 0);
        wait_drain(400);
        stop_run("t1_stop");

        // div=3 periodic; Start held high during RUN must not restart the phase.
        cfg(3, 1'b0);
        Start = 1'b1;
        e0    = cyc + 1;
        push_ticks(e0, 4, 3, 1'b0);
        repeat (6) nxt();
        check("t2_busy", Busy, 1);
        Start = 1'b0;
        wait_drain(40);
        check("t2_busy_end", Busy, 1);
        stop_run("t2_stop");

        // One-shot, config and Start on the same edge.
        Cfg_valid   = 1'b1;
        Cfg_div     = CW'(5);
        Cfg_oneshot = 1'b1;
        Start       = 1'b1;
        e0          = cyc + 1;
        push_ticks(e0, 6, 1, 1'b1);
        nxt();
        Cfg_valid = 1'b0;
        Start     = 1'b0;
        check("t3_busy", Busy, 1);
        wait_drain(20);
        nxt();
        check("t3_busy_drop", Busy, 0);
        check("t3_ready", Cfg_ready, 1);
        repeat (20) nxt();
        check("t3_sq_hold", Sq_out, exp_sq);

        // div=0: Tick every cycle, then Stop on a terminal-count edge.
        cfg(0, 1'b0);
        Start = 1'b1;
        e0    = cyc + 1;
        push_ticks(e0, 1, 5, 1'b0);
        nxt();
        Start = 1'b0;
        while (cyc < e0 + 5) nxt();
        Stop = 1'b1;
        nxt();
        Stop = 1'b0;
        check("t4_tick", Tick, 0);
        check("t4_done", Done, 0);
        check("t4_sq", Sq_out, 0);
        check("t4_busy", Busy, 0);
        check("t4_ready", Cfg_ready, 1);
        exp_sq = 1'b0;

        // Config offered during RUN is held off until IDLE.
        cfg(2, 1'b0);
        Start = 1'b1;
        e0    = cyc + 1;
        push_ticks(e0, 3, 4, 1'b0);
        nxt();
        Start       = 1'b0;
        Cfg_valid   = 1'b1;
        Cfg_div     = CW'(7);
        Cfg_oneshot = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nxt();
            check("t5_ready_run", Cfg_ready, 0);
        end
        wait_drain(30);
        stop_run("t5_stop");
        nxt();
        Cfg_valid = 1'b0;
        Cfg_div   = '0;
        Start     = 1'b1;
        e0        = cyc + 1;
        push_ticks(e0, 8, 2, 1'b0);
        nxt();
        Start = 1'b0;
        wait_drain(30);
        stop_run("t5_stop2");

        // Async reset mid-count restores the default divisor.
        cfg(9, 1'b0);
        Start = 1'b1;
        e0    = cyc + 1;
        push_ticks(e0, 10, 1, 1'b0);
        nxt();
        Start = 1'b0;
        wait_drain(20);
        while (cyc < e0 + 14) nxt();
        check("t6_busy_pre", Busy, 1);
        check("t6_sq_pre", Sq_out, 1);
        Reset_n = 1'b0;
        #1;
        check("t6_rst_tick", Tick, 0);
        check("t6_rst_sq", Sq_out, 0);
        check("t6_rst_busy", Busy, 0);
        check("t6_rst_done", Done, 0);
        check("t6_rst_ready", Cfg_ready, 1);
        exp_sq = 1'b0;
        nxt();
        Reset_n = 1'b1;
        nxt();
        Start = 1'b1;
        e0    = cyc + 1;
        push_ticks(e0, TB_DEF + 1, 2, 1'b0);
        nxt();
        Start = 1'b0;
        wait_drain(300);
        stop_run("t6_stop");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
